// File: rtl/countdown_timer_16bit.sv
// Programmable 16-bit interval timer: controller FSM (IDLE/RUN/PAUSE/DONE) plus count/prescaler datapath.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN to restart from the reload value after each done pulse.
module countdown_timer_16bit #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   presc;
  logic            load_en;
  logic            run_en;
  logic            tick_wrap;
  logic            last_dec;
  logic            load_zero;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
  logic             reload_en;
`endif

  // Datapath status seen by the controller.
  assign tick_wrap = (presc == PS_LAST);
  assign last_dec  = tick_wrap && (count == WIDTH'(1));
  assign load_zero = (load_val == '0);

  // ---------------- Controller ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx  = state;
    load_en   = 1'b0;
    run_en    = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_en = 1'b0;
`endif
    // start restarts from any state and outranks pause and the decrement.
    if (start) begin
      load_en  = 1'b1;
      state_nx = load_zero ? DONE : RUN;
    end else begin
      unique case (state)
        IDLE:  state_nx = IDLE;
        RUN: begin
          if (pause) begin
            state_nx = PAUSE;
          end else begin
            run_en = 1'b1;
            if (last_dec) state_nx = DONE;
          end
        end
        PAUSE: if (!pause) state_nx = RUN;
        DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          // A zero reload value parks in IDLE instead of pulsing done forever.
          if (reload != '0) begin
            reload_en = 1'b1;
            state_nx  = RUN;
          end else begin
            state_nx  = IDLE;
          end
`else
          state_nx = IDLE;
`endif
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      presc  <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else if (load_en) begin
      count  <= load_val;
      presc  <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload <= load_val;
    end else if (reload_en) begin
      count  <= reload;
      presc  <= '0;
`endif
    end else if (run_en) begin
      if (tick_wrap) begin
        presc <= '0;
        if (count != '0) count <= count - WIDTH'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule
